clk_rate_controller: RTL and testbench
======================================

Name: clk_rate_controller

Overview:
- Run-time selectable clock generator. It replaces the per-rate fixed dividers with one shared divider counter and a rate-select state machine.
- Produces a 50%-duty `outgoing_CLK` at one of eight table rates (1 Hz to 10 kHz) from the 100 MHz board clock.
- Rate changes are requested by a direct load or by up/down steps. A change takes effect only at a period boundary, so the output never glitches.
- Feeds LED and PMOD demo logic and acts as the tick source for downstream counters.

Parameters:
- DEFAULT_SEL, 3, rate index loaded at reset (3 = 1 kHz).
- SIM_DIVISOR, 1, every half-period count is divided by this value. It must divide all table entries exactly; 100 is the standard simulation value.

Ports:
- incoming_CLK100MHZ  in  1  100 MHz system clock; all logic is on the rising edge.
- CPU_RESETN  in  1  asynchronous, active-low reset.
- run  in  1  level; 1 = generate the clock, 0 = stop at the next period end.
- load  in  1  single-cycle strobe; request rate index sel_in.
- sel_in  in  3  rate index captured when load = 1.
- rate_up  in  1  single-cycle strobe; request index +1, saturating at 7.
- rate_down  in  1  single-cycle strobe; request index −1, saturating at 0.
- outgoing_CLK  out  1  divided clock output (registered).
- tick  out  1  one-cycle pulse, coincident with each rising edge of outgoing_CLK.
- cur_sel  out  3  rate index currently in effect.
- change_pending  out  1  a requested rate change is waiting for the period boundary.

Behaviour:
- Rate table, half-period counts H[i] (at SIM_DIVISOR = 1):
  - 0: 1 Hz, 50_000_000
  - 1: 10 Hz, 5_000_000
  - 2: 100 Hz, 500_000
  - 3: 1 kHz, 50_000
  - 4: 2 kHz, 25_000
  - 5: 4 kHz, 12_500
  - 6: 5 kHz, 10_000
  - 7: 10 kHz, 5_000
- Counter `ctr` is 26 bits unsigned. Compare value is H[cur_sel]/SIM_DIVISOR − 1.
- Reset values (asynchronous): outgoing_CLK = 0, tick = 0, ctr = 0, cur_sel = DEFAULT_SEL, pend_sel = DEFAULT_SEL, change_pending = 0, state = IDLE.
- State machine, states IDLE, LOW, HIGH:
  - IDLE: outgoing_CLK = 0, ctr held at 0. When run = 1, move to LOW on the next edge.
  - LOW: ctr increments each cycle. When ctr = H−1: outgoing_CLK <= 1, tick <= 1 for one cycle, ctr <= 0, go to HIGH.
  - HIGH: ctr increments each cycle. When ctr = H−1 (period boundary):
    - outgoing_CLK <= 0, ctr <= 0.
    - If change_pending = 1: cur_sel <= pend_sel, change_pending <= 0.
    - Next state is LOW if run = 1, otherwise IDLE.
- Timing: first rising edge occurs H+1 cycles after run rises from IDLE. Steady-state period is 2H cycles, high for H and low for H.
- Requests:
  - Base value = pend_sel if change_pending = 1, otherwise cur_sel.
  - load: pend_sel <= sel_in.
  - rate_up: pend_sel <= min(base+1, 7).
  - rate_down: pend_sel <= max(base−1, 0).
  - Any request sets change_pending = 1.
  - Priority: load > rate_up > rate_down. Simultaneous up and down results in up only.
  - A request that equals cur_sel is still recorded as pending; applying it changes nothing.
- In IDLE, requests apply immediately: cur_sel is updated on the next edge and change_pending never asserts.
- Request arriving on the boundary cycle:
  - cur_sel takes the old pend_sel.
  - The new request is computed from that old pend_sel (base rule) and stays pending for the next boundary.
- run dropping mid-period: the current period completes fully, including its high phase, then the block enters IDLE. No truncated pulse is produced.
- Reset asserted mid-operation: all outputs go to reset values immediately (asynchronous). Deassertion is assumed synchronised upstream.

Decomposition:
- Package clk_rate_pkg holds:
  - RATE_SEL_W = 3, CTR_W = 26.
  - The 8-entry half-period constant table with a lookup function.
  - The state enum {IDLE, LOW, HIGH}.
- Sub-module rate_select_reg holds the pend_sel/cur_sel/change_pending request logic. The divider FSM instantiates it.

Test Plan (all scenarios use SIM_DIVISOR = 100):
- Reset with run = 0 → outgoing_CLK = 0, tick = 0, cur_sel = 3, change_pending = 0. ctr stays 0 for 1000 cycles.
- run = 1 at sel 7 (H = 50) → first tick 51 cycles after run; then period of 100 cycles with 50 high; tick width 1 cycle.
- At sel 3 (H = 500), pulse rate_up mid-LOW phase →
  - change_pending = 1 and cur_sel stays 3 until the HIGH-phase end.
  - Then cur_sel = 4 and the next period is 500 cycles (H = 250).
- Saturation: at sel 7 pulse rate_up twice → pend_sel = 7. At sel 0, rate_down → 0.
- Boundary race: load sel_in = 6 while pending = 5, on the boundary cycle → cur_sel = 5 applied; pend = 6 still pending; applied at the following boundary.
- Drop run during HIGH at sel 7 → high phase completes the full 50 cycles, then IDLE with output 0. CPU_RESETN low mid-HIGH → output 0 in the same cycle.

Source files
------------

// File: rtl/clk_rate_pkg.sv
// Shared types, rate table and request arithmetic for the
// run-time selectable clock generator.
package clk_rate_pkg;

  localparam int RATE_SEL_W = 3;
  localparam int CTR_W      = 26;
  localparam int NUM_RATES  = 8;

  typedef logic [RATE_SEL_W-1:0] sel_t;
  typedef logic [CTR_W-1:0]      ctr_t;

  typedef enum logic [1:0] {
    IDLE,
    LOW,
    HIGH
  } state_t;

  typedef struct packed {
    logic load;
    logic up;
    logic down;
    sel_t sel;
  } rate_req_t;

  // Half-period length in 100 MHz cycles, before simulation scaling
  function automatic ctr_t half_period(input sel_t sel);
    ctr_t h;
    case (sel)
      3'd0:    h = 26'd50_000_000;
      3'd1:    h = 26'd5_000_000;
      3'd2:    h = 26'd500_000;
      3'd3:    h = 26'd50_000;
      3'd4:    h = 26'd25_000;
      3'd5:    h = 26'd12_500;
      3'd6:    h = 26'd10_000;
      default: h = 26'd5_000;
    endcase
    return h;
  endfunction

  // load wins over up, up wins over down; steps saturate
  function automatic sel_t next_sel(
    input rate_req_t req,
    input sel_t      base
  );
    sel_t n;
    n = base;
    priority case (1'b1)
      req.load: n = req.sel;
      req.up:   n = (base == '1) ? base : base + 1'b1;
      req.down: n = (base == '0) ? base : base - 1'b1;
      default:  n = base;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/rate_select_reg.sv
// Rate request register: holds the rate in effect and a pending
// request that is promoted only at a period boundary.
module rate_select_reg
  import clk_rate_pkg::*;
#(
  parameter int DEFAULT_SEL = 3
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      idle,
  input  logic      boundary,
  input  rate_req_t req,
  output sel_t      cur_sel,
  output logic      change_pending
);

  sel_t pend_sel;
  sel_t base;
  sel_t nxt;
  logic req_v;

  always_comb begin
    base  = change_pending ? pend_sel : cur_sel;
    nxt   = next_sel(req, base);
    req_v = req.load | req.up | req.down;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_sel        <= sel_t'(DEFAULT_SEL);
      pend_sel       <= sel_t'(DEFAULT_SEL);
      change_pending <= 1'b0;
    end else if (idle) begin
      // No period running: apply straight away
      change_pending <= 1'b0;
      if (req_v) begin
        cur_sel  <= nxt;
        pend_sel <= nxt;
      end else if (change_pending) begin
        cur_sel <= pend_sel;
      end
    end else begin
      if (boundary && change_pending) begin
        cur_sel        <= pend_sel;
        change_pending <= 1'b0;
      end
      if (req_v) begin
        pend_sel       <= nxt;
        change_pending <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/clk_rate_controller.sv
// Shared-counter clock divider with glitch-free rate switching
// at period boundaries.
module clk_rate_controller
  import clk_rate_pkg::*;
#(
  parameter int DEFAULT_SEL = 3,
  parameter int SIM_DIVISOR = 1
) (
  input  logic                  incoming_CLK100MHZ,
  input  logic                  CPU_RESETN,
  input  logic                  run,
  input  logic                  load,
  input  logic [RATE_SEL_W-1:0] sel_in,
  input  logic                  rate_up,
  input  logic                  rate_down,
  output logic                  outgoing_CLK,
  output logic                  tick,
  output logic [RATE_SEL_W-1:0] cur_sel,
  output logic                  change_pending
);

  state_t    state;
  ctr_t      ctr;
  ctr_t      lim;
  ctr_t      lim_tbl [NUM_RATES];
  logic      at_lim;
  logic      boundary;
  rate_req_t req;

  // Compare values folded to constants at elaboration
  for (genvar g = 0; g < NUM_RATES; g++) begin : g_lim
    localparam ctr_t L =
      half_period(sel_t'(g)) / ctr_t'(SIM_DIVISOR) - ctr_t'(1);
    assign lim_tbl[g] = L;
  end

  always_comb begin
    req.load = load;
    req.up   = rate_up;
    req.down = rate_down;
    req.sel  = sel_in;
  end

  assign lim      = lim_tbl[cur_sel];
  assign at_lim   = (ctr == lim);
  assign boundary = (state == HIGH) && at_lim;

  rate_select_reg #(
    .DEFAULT_SEL(DEFAULT_SEL)
  ) u_sel (
    .clk           (incoming_CLK100MHZ),
    .rst_n         (CPU_RESETN),
    .idle          (state == IDLE),
    .boundary      (boundary),
    .req           (req),
    .cur_sel       (cur_sel),
    .change_pending(change_pending)
  );

  always_ff @(posedge incoming_CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      state        <= IDLE;
      ctr          <= '0;
      outgoing_CLK <= 1'b0;
      tick         <= 1'b0;
    end else begin
      tick <= 1'b0;
      unique case (state)
        IDLE: begin
          ctr          <= '0;
          outgoing_CLK <= 1'b0;
          if (run) state <= LOW;
        end
        LOW: begin
          if (at_lim) begin
            ctr          <= '0;
            outgoing_CLK <= 1'b1;
            tick         <= 1'b1;
            state        <= HIGH;
          end else begin
            ctr <= ctr + 1'b1;
          end
        end
        HIGH: begin
          // run is only looked at here so a period is never cut short
          if (at_lim) begin
            ctr          <= '0;
            outgoing_CLK <= 1'b0;
            state        <= run ? LOW : IDLE;
          end else begin
            ctr <= ctr + 1'b1;
          end
        end
        default: begin
          ctr          <= '0;
          outgoing_CLK <= 1'b0;
          state        <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_clk_rate_controller.sv
// Directed bench for clk_rate_controller with scaled-down
// half periods (SIM_DIVISOR = 100).
module tb_clk_rate_controller;

  logic       clk;
  logic       rst_n;
  logic       run;
  logic       load;
  logic [2:0] sel_in;
  logic       rate_up;
  logic       rate_down;
  logic       outgoing_CLK;
  logic       tick;
  logic [2:0] cur_sel;
  logic       change_pending;

  int errs   = 0;
  int checks = 0;

  clk_rate_controller #(
    .DEFAULT_SEL(3),
    .SIM_DIVISOR(100)
  ) dut (
    .incoming_CLK100MHZ(clk),
    .CPU_RESETN        (rst_n),
    .run               (run),
    .load              (load),
    .sel_in            (sel_in),
    .rate_up           (rate_up),
    .rate_down         (rate_down),
    .outgoing_CLK      (outgoing_CLK),
    .tick              (tick),
    .cur_sel           (cur_sel),
    .change_pending    (change_pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic wait_tick(
    input  string tag,
    output int    n
  );
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!tick && n < 3000);
    if (!tick) chk({tag, "_timeout"}, 0, 1);
  endtask

  task automatic wait_fall(input string tag);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (outgoing_CLK && n < 3000);
    if (outgoing_CLK) chk({tag, "_timeout"}, 0, 1);
  endtask

  // Starts on a tick sample; ends on the next tick sample
  task automatic measure(
    input  string tag,
    output int    per,
    output int    hi
  );
    per = 0;
    hi  = 1;
    do begin
      @(negedge clk);
      per++;
      if (!tick && outgoing_CLK) hi++;
    end while (!tick && per < 3000);
    if (!tick) chk({tag, "_timeout"}, 0, 1);
  endtask

  task automatic idle_req(
    input logic       ld,
    input logic [2:0] s,
    input logic       up,
    input logic       dn
  );
    load      = ld;
    sel_in    = s;
    rate_up   = up;
    rate_down = dn;
    @(negedge clk);
    load      = 1'b0;
    rate_up   = 1'b0;
    rate_down = 1'b0;
  endtask

  initial begin
    int n;
    int per;
    int hi;
    int act;

    rst_n     = 1'b0;
    run       = 1'b0;
    load      = 1'b0;
    sel_in    = 3'd0;
    rate_up   = 1'b0;
    rate_down = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_out", outgoing_CLK, 0);
    chk("rst_tick", tick, 0);
    chk("rst_sel", cur_sel, 3);
    chk("rst_pend", change_pending, 0);
    rst_n = 1'b1;

    act = 0;
    repeat (1000) begin
      @(negedge clk);
      if (dut.ctr != 0 || outgoing_CLK || tick) act++;
    end
    chk("idle_hold", act, 0);

    // Requests in IDLE land on the next edge
    idle_req(1'b1, 3'd0, 1'b0, 1'b0);
    chk("idle_load0", cur_sel, 0);
    chk("idle_pend", change_pending, 0);
    idle_req(1'b0, 3'd0, 1'b0, 1'b1);
    chk("sat_down", cur_sel, 0);
    idle_req(1'b0, 3'd0, 1'b1, 1'b1);
    chk("up_over_down", cur_sel, 1);
    idle_req(1'b1, 3'd7, 1'b0, 1'b0);
    chk("idle_load7", cur_sel, 7);
    idle_req(1'b0, 3'd0, 1'b1, 1'b0);
    chk("idle_sat_up", cur_sel, 7);

    // sel 7: H = 50
    run = 1'b1;
    wait_tick("first7", n);
    chk("first_tick7", n, 51);
    chk("first_high7", outgoing_CLK, 1);
    measure("per7", per, hi);
    chk("period7", per, 100);
    chk("high7", hi, 50);
    @(negedge clk);
    chk("tick_width", tick, 0);

    // Two up steps while running at 7 stay saturated
    rate_up = 1'b1;
    repeat (2) @(negedge clk);
    rate_up = 1'b0;
    chk("sat_up_pend", change_pending, 1);
    chk("sat_up_cur", cur_sel, 7);
    wait_fall("sat_fall");
    chk("sat_up_apply", cur_sel, 7);
    chk("sat_up_clear", change_pending, 0);

    // Drop run in HIGH: full high phase then IDLE
    wait_tick("drop", n);
    hi = 1;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (hi == 10) run = 1'b0;
      if (!outgoing_CLK) break;
      hi++;
    end
    chk("drop_high", hi, 50);
    act = 0;
    repeat (300) begin
      @(negedge clk);
      if (outgoing_CLK || tick) act++;
    end
    chk("drop_quiet", act, 0);

    // sel 3 with an up step in the LOW phase
    idle_req(1'b1, 3'd3, 1'b0, 1'b0);
    chk("load3", cur_sel, 3);
    run = 1'b1;
    wait_tick("first3", n);
    chk("first_tick3", n, 501);
    wait_fall("fall3");
    repeat (100) @(negedge clk);
    rate_up = 1'b1;
    @(negedge clk);
    rate_up = 1'b0;
    chk("up_pend", change_pending, 1);
    chk("up_cur", cur_sel, 3);
    wait_tick("up_tick", n);
    chk("up_hold_cur", cur_sel, 3);
    chk("up_hold_pend", change_pending, 1);
    wait_fall("up_fall");
    chk("up_apply", cur_sel, 4);
    chk("up_clear", change_pending, 0);
    wait_tick("low4", n);
    chk("low4", n, 250);
    measure("per4", per, hi);
    chk("period4", per, 500);
    chk("high4", hi, 250);

    // Boundary race: pending 5, load 6 on the boundary cycle
    rate_up = 1'b1;
    @(negedge clk);
    rate_up = 1'b0;
    chk("race_pend5", change_pending, 1);
    repeat (248) @(negedge clk);
    load   = 1'b1;
    sel_in = 3'd6;
    @(negedge clk);
    load = 1'b0;
    chk("race_edge", outgoing_CLK, 0);
    chk("race_cur5", cur_sel, 5);
    chk("race_pend6", change_pending, 1);
    wait_tick("low5", n);
    chk("low5", n, 125);
    wait_fall("race_fall");
    chk("race_cur6", cur_sel, 6);
    chk("race_clear", change_pending, 0);
    wait_tick("low6", n);
    chk("low6", n, 100);
    measure("per6", per, hi);
    chk("period6", per, 200);
    chk("high6", hi, 100);

    // Asynchronous reset in the middle of HIGH
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_out", outgoing_CLK, 0);
    chk("arst_tick", tick, 0);
    chk("arst_sel", cur_sel, 3);
    chk("arst_pend", change_pending, 0);
    @(negedge clk);
    run   = 1'b0;
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
